// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the convolution pipeline blocks.
//   PIXEL_DATAW  - pixel bit width
//   IMAGE_WIDTH  - active (unpadded) image width in pixels
//   FILTER_SIZE  - convolution kernel edge length
//   pixel_t      - one grayscale pixel
//   pad_state_t  - pad_inserter FSM states
//   pad_row_len  - padded row length for a given active width
package conv_pkg;

   localparam int PIXEL_DATAW = 8;
   localparam int IMAGE_WIDTH = 512;
   localparam int FILTER_SIZE = 3;

   typedef logic [7:0] pixel_t;

   typedef enum logic [2:0] {
      TOP,
      LEFT,
      DATA,
      RIGHT,
      BOT
   } pad_state_t;

   // A 3x3 kernel needs one border pixel on each side of a row.
   function automatic int pad_row_len(input int width);
      return width + FILTER_SIZE - 1;
   endfunction

endpackage

// File: rtl/pad_inserter_if.sv
// pad_inserter_if: pixel stream bundle around pad_inserter.
//   Handshake: a pixel moves across a boundary on a rising clk edge where
//   its valid and the receiving side's ready are both high; a producer
//   holds data stable while valid is high and ready is low.
//   Upstream  : i_valid, i_x, i_eof (to DUT), o_ready (from DUT)
//   Downstream: o_valid, o_y (from DUT), i_ready (to DUT)
//   Status    : o_err (from DUT), sticky protocol-error flag
//   slave modport  - pad_inserter side
//   master modport - environment side (source + sink)
interface pad_inserter_if #(
   parameter int PIXEL_DATAW = conv_pkg::PIXEL_DATAW
);

   logic                   i_valid;
   logic [PIXEL_DATAW-1:0] i_x;
   logic                   i_eof;
   logic                   o_ready;
   logic                   o_valid;
   logic [PIXEL_DATAW-1:0] o_y;
   logic                   i_ready;
   logic                   o_err;

   modport slave (
      input  i_valid, i_x, i_eof, i_ready,
      output o_ready, o_valid, o_y, o_err
   );

   modport master (
      output i_valid, i_x, i_eof, i_ready,
      input  o_ready, o_valid, o_y, o_err
   );

endinterface

// File: rtl/stream_reg.sv
// stream_reg: single registered ready/valid slice.
//   i_valid/i_data : pixel offered by the producer this cycle
//   i_ready        : downstream ready
//   o_valid/o_data : registered output pixel
//   o_advance      : slice can take a new pixel this cycle (empty or
//                    being drained); the producer only moves on when high
module stream_reg #(
   parameter int DATAW = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   input  logic [DATAW-1:0] i_data,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [DATAW-1:0] o_data,
   output logic             o_advance
);

   logic             r_valid;
   logic [DATAW-1:0] r_data;

   assign o_advance = !r_valid || i_ready;
   assign o_valid   = r_valid;
   assign o_data    = r_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_advance) begin
         r_valid <= i_valid;
         // Data only changes on a real pixel; bubbles keep the last value.
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

endmodule

// File: rtl/pad_inserter.sv
// pad_inserter: wraps a raw WIDTH-wide frame in a one-pixel zero border
// (top row, left/right columns, bottom row) for the 3x3 convolution stage.
//   clk, reset  : clock, synchronous active-high reset
//   bus (slave) : upstream pixels in, padded pixels out, sticky o_err
//   o_state     : current FSM state (debug visibility)
//   o_frame_cnt : completed-frame counter, present only when
//                 PAD_INSERTER_FRAME_CNT_EN is defined
// Output is one register stage; an accepted pixel appears on o_y the next
// cycle. o_ready is combinational from i_ready through the slice advance.
module pad_inserter #(
   parameter int WIDTH       = conv_pkg::IMAGE_WIDTH,
   parameter int PIXEL_DATAW = conv_pkg::PIXEL_DATAW
) (
   input  logic                 clk,
   input  logic                 reset,
   pad_inserter_if.slave        bus,
   output conv_pkg::pad_state_t o_state
`ifdef PAD_INSERTER_FRAME_CNT_EN
   ,
   output logic [15:0]          o_frame_cnt
`endif
);

   import conv_pkg::*;

   // col counts pixels emitted in the current padded row: 0..WIDTH+1.
   // LEFT is col 0, image pixels are cols 1..WIDTH, RIGHT is col WIDTH+1.
   localparam logic [9:0] LAST_COL  = 10'(pad_row_len(WIDTH) - 1);
   localparam logic [9:0] DATA_LAST = 10'(WIDTH);

   pad_state_t             r_state;
   logic [9:0]             r_col;
   logic                   r_eof_pending;
   logic                   r_err;

   logic                   w_advance;
   logic                   w_prod_valid;
   logic [PIXEL_DATAW-1:0] w_prod_data;
   logic                   w_fire;
   logic                   w_row_end;
   logic                   w_frame_done;

   // Every state except DATA produces a zero each cycle; DATA forwards
   // upstream pixels only when one is offered.
   always_comb begin
      w_prod_valid = 1'b1;
      w_prod_data  = '0;
      if (r_state == DATA) begin
         w_prod_valid = bus.i_valid;
         w_prod_data  = bus.i_x;
      end
   end

   assign bus.o_ready  = w_advance && (r_state == DATA);
   assign w_fire       = w_advance && w_prod_valid;
   assign w_row_end    = (r_col == LAST_COL);
   assign w_frame_done = w_fire && (r_state == BOT) && w_row_end;

   assign bus.o_err = r_err;
   assign o_state   = r_state;

   stream_reg #(
      .DATAW (PIXEL_DATAW)
   ) u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .i_valid   (w_prod_valid),
      .i_data    (w_prod_data),
      .i_ready   (bus.i_ready),
      .o_valid   (bus.o_valid),
      .o_data    (bus.o_y),
      .o_advance (w_advance)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= TOP;
         r_col         <= '0;
         r_eof_pending <= 1'b0;
         r_err         <= 1'b0;
      end else if (w_fire) begin
         unique case (r_state)
            TOP: begin
               if (w_row_end) begin
                  r_col   <= '0;
                  r_state <= LEFT;
               end else begin
                  r_col <= r_col + 10'd1;
               end
            end
            LEFT: begin
               r_col   <= r_col + 10'd1;
               r_state <= DATA;
            end
            DATA: begin
               r_col <= r_col + 10'd1;
               if (r_col == DATA_LAST) begin
                  // Only the last pixel of a row may close the frame.
                  r_state       <= RIGHT;
                  r_eof_pending <= bus.i_eof;
               end else if (bus.i_eof) begin
                  // Misplaced end-of-frame: flag it, keep row framing.
                  r_err <= 1'b1;
               end
            end
            RIGHT: begin
               r_col   <= '0;
               r_state <= r_eof_pending ? BOT : LEFT;
            end
            BOT: begin
               if (w_row_end) begin
                  r_col         <= '0;
                  r_state       <= TOP;
                  r_eof_pending <= 1'b0;
               end else begin
                  r_col <= r_col + 10'd1;
               end
            end
            default: begin
               r_col   <= '0;
               r_state <= TOP;
            end
         endcase
      end
   end

`ifdef PAD_INSERTER_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   // Wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame_cnt <= '0;
      end else if (w_frame_done) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign o_frame_cnt = r_frame_cnt;
`else
   logic w_unused;
   assign w_unused = w_frame_done;
`endif

endmodule

// File: tb/tb_pad_inserter.sv
// tb_pad_inserter: directed bench for pad_inserter (WIDTH=512).
module tb_pad_inserter;

   import conv_pkg::*;

   logic       clk;
   logic       reset;
   pad_state_t w_state;
`ifdef PAD_INSERTER_FRAME_CNT_EN
   logic [15:0] w_frame_cnt;
`endif

   pad_inserter_if #(.PIXEL_DATAW(8)) bus ();

   pad_inserter #(
      .WIDTH       (512),
      .PIXEL_DATAW (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .o_state     (w_state)
`ifdef PAD_INSERTER_FRAME_CNT_EN
      ,
      .o_frame_cnt (w_frame_cnt)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] in_x[$];
   bit         in_eof[$];

   int stall_viol;
   int ready_drop;
   int err_seen_idx;
   bit timed_out;

   task automatic do_reset();
      bus.i_valid = 1'b0;
      bus.i_x     = '0;
      bus.i_eof   = 1'b0;
      bus.i_ready = 1'b1;
      reset       = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      in_x.delete();
      in_eof.delete();
      exp_q.delete();
      got_q.delete();
   endtask

   // ---------------- stimulus / expected model ----------------
   // Appends an H-row frame (pixel = (row*3+col)%256) to the input queues
   // and its padded image to exp_q. bad_eof_at flags an extra early eof.
   task automatic build_frame(input int h, input int bad_eof_at);
      for (int c = 0; c < 514; c++) exp_q.push_back(8'h00);
      for (int r = 0; r < h; r++) begin
         exp_q.push_back(8'h00);
         for (int c = 0; c < 512; c++) begin
            in_x.push_back(8'((r * 3 + c) % 256));
            in_eof.push_back(((r == h - 1) && (c == 511)) || ((r * 512 + c) == bad_eof_at));
            exp_q.push_back(8'((r * 3 + c) % 256));
         end
         exp_q.push_back(8'h00);
      end
      for (int c = 0; c < 514; c++) exp_q.push_back(8'h00);
   endtask

   // After input runs dry the block emits the next top pad and left pad.
   task automatic add_tail();
      for (int c = 0; c < 515; c++) exp_q.push_back(8'h00);
   endtask

   // ---------------- driver / collector ----------------
   // ready_mode 0: i_ready=1; 1: pattern 1,0,0,1. bubble_at: input index
   // where i_valid drops for 5 cycles. abort_at: stop once that many
   // inputs were accepted. Ends after 12 idle cycles once input is drained.
   task automatic run_stream(input int ready_mode, input int bubble_at, input int abort_at);
      int  idx = 0;
      int  cyc = 0;
      int  idle = 0;
      int  bubble_left = 0;
      bit  bubble_done = 0;
      bit  prev_stall = 0;
      bit  xfer;
      logic [7:0] prev_y = '0;
      stall_viol   = 0;
      ready_drop   = 0;
      err_seen_idx = -1;
      timed_out    = 0;
      while (1) begin
         bus.i_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (bubble_at >= 0 && idx == bubble_at && !bubble_done) begin
            bubble_left = 5;
            bubble_done = 1;
         end
         if (idx < in_x.size() && bubble_left == 0) begin
            bus.i_valid = 1'b1;
            bus.i_x     = in_x[idx];
            bus.i_eof   = in_eof[idx];
         end else begin
            bus.i_valid = 1'b0;
            bus.i_x     = 8'($urandom_range(0, 255));
            bus.i_eof   = 1'b0;
         end
         @(negedge clk);
         if (prev_stall && (bus.o_valid !== 1'b1 || bus.o_y !== prev_y)) stall_viol++;
         prev_stall = bus.o_valid && !bus.i_ready;
         prev_y     = bus.o_y;
         if (w_state == DATA && bus.i_ready && !bus.o_ready) ready_drop++;
         if (bus.o_err && err_seen_idx < 0) err_seen_idx = idx;
         xfer = bus.o_valid && bus.i_ready;
         if (xfer) got_q.push_back(bus.o_y);
         if (bus.i_valid && bus.o_ready) idx++;
         if (bubble_left > 0) bubble_left--;
         if (idx == in_x.size() && !xfer) idle++;
         else idle = 0;
         cyc++;
         @(posedge clk);
         #1;
         if (idle >= 12) break;
         if (abort_at >= 0 && idx >= abort_at) break;
         if (cyc >= 20000) begin
            timed_out = 1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %0b want 0", bus.o_valid); end
      checks++;
      if (bus.o_y !== 8'h00) begin errors++; $display("FAIL reset_o_y: got %h want 00", bus.o_y); end
      checks++;
      if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reset_o_err: got %0b want 0", bus.o_err); end
      checks++;
      if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL reset_o_ready: got %0b want 0", bus.o_ready); end
      checks++;
      if (w_state !== TOP) begin errors++; $display("FAIL reset_state: got %0d want %0d", w_state, TOP); end
   endtask

   task automatic test_frame();
      int n_bad = 0;
      int first = -1;
      do_reset();
      build_frame(2, -1);
      add_tail();
      run_stream(0, -1, -1);
      checks++;
      if (timed_out) begin errors++; $display("FAIL frame_timeout: got timeout want completion"); end
      checks++;
      if (got_q.size() != 2571) begin errors++; $display("FAIL frame_count: got %0d want 2571", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin n_bad++; if (first < 0) first = i; end
      checks++;
      if (n_bad != 0) begin
         errors++;
         $display("FAIL frame_seq: %0d bad, first idx %0d got %h want %h", n_bad, first, got_q[first], exp_q[first]);
      end
      if (got_q.size() > 1027) begin
         checks++;
         if (got_q[515] !== 8'h00 || got_q[516] !== 8'h01 || got_q[517] !== 8'h02 || got_q[1027] !== 8'h00) begin
            errors++;
            $display("FAIL frame_points: got %h %h %h %h want 00 01 02 00", got_q[515], got_q[516], got_q[517], got_q[1027]);
         end
      end
      checks++;
      if (bus.o_err !== 1'b0) begin errors++; $display("FAIL frame_err: got %0b want 0", bus.o_err); end
   endtask

   task automatic test_backpressure();
      int n_bad = 0;
      int first = -1;
      do_reset();
      build_frame(3, -1);
      add_tail();
      run_stream(1, -1, -1);
      checks++;
      if (got_q.size() != 3085) begin errors++; $display("FAIL bp_count: got %0d want 3085 (timeout=%0b)", got_q.size(), timed_out); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin n_bad++; if (first < 0) first = i; end
      checks++;
      if (n_bad != 0) begin
         errors++;
         $display("FAIL bp_seq: %0d bad, first idx %0d got %h want %h", n_bad, first, got_q[first], exp_q[first]);
      end
      checks++;
      if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_viol); end
   endtask

   task automatic test_bubbles();
      int n_bad = 0;
      int first = -1;
      do_reset();
      build_frame(1, -1);
      add_tail();
      run_stream(0, 100, -1);
      checks++;
      if (ready_drop != 0) begin errors++; $display("FAIL bubble_ready: got %0d DATA cycles not ready want 0", ready_drop); end
      checks++;
      if (got_q.size() != 2057) begin errors++; $display("FAIL bubble_count: got %0d want 2057", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin n_bad++; if (first < 0) first = i; end
      checks++;
      if (n_bad != 0) begin
         errors++;
         $display("FAIL bubble_seq: %0d bad, first idx %0d got %h want %h", n_bad, first, got_q[first], exp_q[first]);
      end
   endtask

   task automatic test_bad_eof();
      int n_bad = 0;
      int first = -1;
      do_reset();
      build_frame(1, 200);
      add_tail();
      run_stream(0, -1, -1);
      checks++;
      if (err_seen_idx != 201) begin errors++; $display("FAIL eof_err_time: got err after %0d accepts want 201", err_seen_idx); end
      checks++;
      if (bus.o_err !== 1'b1) begin errors++; $display("FAIL eof_err_sticky: got %0b want 1", bus.o_err); end
      checks++;
      if (got_q.size() != 2057) begin errors++; $display("FAIL eof_count: got %0d want 2057", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin n_bad++; if (first < 0) first = i; end
      checks++;
      if (n_bad != 0) begin
         errors++;
         $display("FAIL eof_seq: %0d bad, first idx %0d got %h want %h", n_bad, first, got_q[first], exp_q[first]);
      end
   endtask

   task automatic test_back_to_back();
      int n_bad = 0;
      int first = -1;
      do_reset();
      build_frame(1, -1);
      build_frame(1, -1);
      add_tail();
      run_stream(0, -1, -1);
      checks++;
      if (got_q.size() != 3599) begin errors++; $display("FAIL b2b_count: got %0d want 3599", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin n_bad++; if (first < 0) first = i; end
      checks++;
      if (n_bad != 0) begin
         errors++;
         $display("FAIL b2b_seq: %0d bad, first idx %0d got %h want %h", n_bad, first, got_q[first], exp_q[first]);
      end
      if (got_q.size() > 2058) begin
         checks++;
         if (got_q[2057] !== 8'h00 || got_q[2058] !== 8'h01) begin
            errors++;
            $display("FAIL b2b_second_top: got %h %h want 00 01", got_q[2057], got_q[2058]);
         end
      end
`ifdef PAD_INSERTER_FRAME_CNT_EN
      checks++;
      if (w_frame_cnt !== 16'd2) begin errors++; $display("FAIL b2b_frame_cnt: got %0d want 2", w_frame_cnt); end
`endif
   endtask

   task automatic test_mid_reset();
      int n_bad = 0;
      int first = -1;
      do_reset();
      build_frame(3, 5);
      run_stream(0, -1, 812);
      checks++;
      if (bus.o_err !== 1'b1) begin errors++; $display("FAIL mrst_err_before: got %0b want 1", bus.o_err); end
      bus.i_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_err !== 1'b0 || w_state !== TOP) begin
         errors++;
         $display("FAIL mrst_after: got valid=%0b err=%0b state=%0d want 0 0 %0d", bus.o_valid, bus.o_err, w_state, TOP);
      end
      do_reset();
      build_frame(1, -1);
      add_tail();
      run_stream(0, -1, -1);
      checks++;
      if (got_q.size() != 2057) begin errors++; $display("FAIL mrst_count: got %0d want 2057", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin n_bad++; if (first < 0) first = i; end
      checks++;
      if (n_bad != 0) begin
         errors++;
         $display("FAIL mrst_seq: %0d bad, first idx %0d got %h want %h", n_bad, first, got_q[first], exp_q[first]);
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      reset = 1'b1;
      test_reset();
      test_frame();
      test_backpressure();
      test_bubbles();
      test_bad_eof();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pad_inserter.md
Name: pad_inserter

Overview:
- Upstream neighbour of the 3x3 convolution stage.
- Accepts a raw, unpadded 512-pixel-wide grayscale stream of any height, with an end-of-frame marker on the last pixel.
- Emits the zero-padded stream the convolution stage expects:
  - one all-zero row of WIDTH+2 pixels before the frame;
  - one zero pixel on each side of every image row;
  - one all-zero row of WIDTH+2 pixels after the frame.
- Ready/valid on both sides; the output is a registered stage.

Parameters:
- WIDTH, 512, active image width in pixels; padded row = WIDTH+2.
- PIXEL_DATAW, 8, pixel bit width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_valid  in  1  upstream pixel valid
- i_x  in  PIXEL_DATAW  unpadded pixel, unsigned
- i_eof  in  1  marks last pixel of frame; qualified by i_valid && o_ready
- o_ready  out  1  this block accepts i_x this cycle
- o_valid  out  1  o_y holds a valid padded pixel
- o_y  out  PIXEL_DATAW  padded pixel
- i_ready  in  1  downstream (conv) ready
- o_err  out  1  sticky protocol-error flag

Behaviour:
- Clock clk; reset is synchronous, active-high.
- Reset values: o_valid=0, o_y=0, o_err=0, state=TOP, col=0, eof_pending=0.
- Output register rules:
  - advance = !o_valid || i_ready.
  - When advance, the register loads the next produced pixel; o_valid=1 if a pixel is produced, else 0.
  - When !advance, o_y and o_valid hold.
  - Latency: accepted input pixel appears on o_y the next cycle.
- o_ready = advance && (state==DATA). It is combinational from i_ready; there is no other input acceptance path.
- col: 10-bit counter of pixels emitted in the current padded row, 0..WIDTH+1. It increments only on a produced pixel while advance.
- FSM (each produced pixel requires advance):
  - TOP: emit 0 per cycle; after WIDTH+2 pixels -> LEFT.
  - LEFT: emit one 0 -> DATA.
  - DATA: a pixel is produced only when i_valid && o_ready, and o_y <= i_x. After the WIDTH-th accepted pixel -> RIGHT, and latch eof_pending = i_eof of that pixel.
  - RIGHT: emit one 0; if eof_pending -> BOT, else -> LEFT.
  - BOT: emit 0 per cycle; after WIDTH+2 pixels -> TOP with eof_pending cleared, so the next frame starts with its own top pad immediately.
- DATA with i_valid=0: no pixel produced; o_valid drops to 0 if advance.
- i_eof rules:
  - i_eof on any accepted pixel other than the WIDTH-th of a row is ignored for framing and sets o_err=1.
  - o_err stays set until reset.
- Frame of H rows: output is exactly (H+2)*(WIDTH+2) pixels.
  - Minimum H=1: TOP, LEFT, DATA, RIGHT, BOT.
- i_ready=0 stalls all states; no pixel is lost or duplicated; o_y is stable while o_valid && !i_ready.
- Reset mid-frame discards the partial frame; the first cycle after reset begins TOP.
- Pixels are unsigned and passed unmodified; no arithmetic on data.

Optional Feature:
- Macro: PAD_INSERTER_FRAME_CNT_EN.
- Defined:
  - Adds output port o_frame_cnt [15:0], reset 0.
  - Increments by 1, wrapping at 65535->0, on the cycle the last BOT pixel is loaded into the output register.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package conv_pkg holds:
  - PIXEL_DATAW=8, IMAGE_WIDTH=512, FILTER_SIZE=3;
  - typedef pixel_t (logic [7:0]);
  - typedef enum pad_state_t {TOP, LEFT, DATA, RIGHT, BOT}.
- The pipeline register slice is a natural sub-module: stream_reg (data/valid/ready, advance logic). The FSM stays in pad_inserter.

Test Plan:
- Frame of H=2, i_x = (row*3+col)%256, i_ready=1, i_valid=1 continuously:
  - exactly 4*514=2056 valid outputs;
  - pixels 0..513 and 1542..2055 are 0;
  - output index 514 = 0, 515 = 0x00, 516 = 0x01, 1027 = 0;
  - o_err=0.
- Downstream backpressure: i_ready toggled 1,0,0,1 repeating through an H=3 frame:
  - output sequence identical to the unstalled run;
  - o_y constant during every o_valid && !i_ready cycle.
- Upstream bubbles: i_valid low for 5 cycles at col 100:
  - o_ready stays 1 in DATA;
  - no zero inserted mid-row;
  - row still has exactly 514 pixels.
- Bad EOF: i_eof=1 on pixel 200 of row 0:
  - o_err=1 next cycle and stays 1;
  - framing continues; the frame ends only on the eof at pixel 511.
- Back-to-back frames H=1 then H=1 with no idle gap:
  - 3*514 outputs each, 3084 total;
  - second TOP pad starts immediately after first BOT.
  - With PAD_INSERTER_FRAME_CNT_EN: o_frame_cnt = 2.
- Reset asserted mid-DATA at row 1 col 300:
  - next cycle o_valid=0, o_err=0;
  - the next frame begins with 514 zeros.
